pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined add/subtract unit; successor to the team's 8-bit ripple-carry adder. Operand width is split into STAGES equal chunks, with one chunk added per pipeline stage and the carry registered between stages. Sits between producer and consumer logic using valid/ready handshakes. Sustains one operation per clock and adds a subtract mode, signed overflow and zero flags.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES (elaboration error otherwise).
STAGES, 4, pipeline depth = number of chunks; 1 <= STAGES <= WIDTH.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
a  in  WIDTH  operand A (unsigned or two's complement).
b  in  WIDTH  operand B.
cin  in  1  carry-in (add) / borrow-in (sub).
sub  in  1  0 = add, 1 = subtract.
out_valid  out  1  result beat valid.
out_ready  in  1  consumer accepts result this cycle.
sum  out  WIDTH  result.
cout  out  1  carry-out (add); not-borrow (sub).
ovf  out  1  signed overflow.
zero  out  1  sum == 0.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). While rst=1, all stage valid bits, sum, cout, ovf and zero are 0 and out_valid=0. in_ready is 1 immediately after rst deasserts. In-flight beats are discarded on reset.
- Arithmetic: b_eff = sub ? ~b : b; c0 = cin ^ sub.
  - Result: {cout, sum} = a + b_eff + c0 at width WIDTH+1.
  - With sub=1, this gives sum = a - b - cin and cout = 1 iff no borrow.
  - ovf = carry into bit WIDTH-1 XOR cout.
  - zero = (sum == 0), computed from final-stage result bits.
- Chunking: C = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*C +: C] of a and b_eff with the carry registered from stage k-1; stage 0 uses c0.
  - Unconsumed upper operand chunks travel down the pipeline in skew registers.
  - Completed lower sum chunks travel in de-skew registers, so all bits of one beat emerge together.
- Latency: a beat accepted at edge N (in_valid & in_ready) is presented with out_valid=1 after edge N+STAGES-1 completes, i.e. visible during cycle N+STAGES-1 relative to the accept edge. Defined as exactly STAGES register stages.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - On stall, every stage register, including valid bits, holds its value. No beat is dropped or duplicated.
  - When not stalled, all stages advance each cycle. Stage 0 valid is loaded with in_valid & in_ready.
  - sum/cout/ovf/zero are stable whenever out_valid=1 and out_ready=0.
- Output values when out_valid=0 are don't-care for the consumer; the implementation holds the last values.
- Throughput: one beat per cycle with out_ready held high; bubbles propagate as valid=0.
- Simultaneous accept and emit in the same cycle is legal and is the normal steady state.
- Wrap-around: 0xFFFF_FFFF + 1 wraps to 0 with cout=1. No saturation.
- STAGES=1: a single registered full-width add, latency 1, same handshake.

Decomposition:
- Shared package addsub_pkg holds:
  - typedef for the stage control bundle {valid, carry};
  - localparam function for chunk width (WIDTH/STAGES);
  - the mode encoding constants ADD=0, SUB=1.
- One sub-module, addsub_chunk: combinational C-bit adder with carry-in; outputs sum chunk, carry-out and carry into its MSB (used for ovf in the top chunk). It is instantiated STAGES times via generate.
- Pipeline registers, skew/de-skew and the handshake live in the top module.

Test Plan:
- WIDTH=32, STAGES=4, sub=0, a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> 4 cycles later sum=0x0000_0000, cout=1, ovf=0, zero=1.
- a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x8000_0000, ovf=1, cout=0. Then a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Six back-to-back beats (a=i, b=0x10*i) with out_ready held low for cycles 3-5 -> in_ready low exactly while out_valid & ~out_ready; all six results a+b emerge in order, none lost or repeated, outputs stable during the stall.
- Assert rst for one cycle with 3 beats in flight -> out_valid=0 and flags 0 during rst; no stale beat appears afterwards; the next accepted beat returns after exactly 4 cycles.
- WIDTH=8, STAGES=1, a=0xFF, b=0x01, cin=1, sub=0 -> next cycle sum=0x01, cout=1. Then a=0x80, b=0x01, sub=1, cin=0 -> sum=0x7F, ovf=1, cout=1.
- Random 10k beats, WIDTH=32 with STAGES in {1,2,4,8}, random out_ready -> all fields match the reference model (a + b_eff + c0) and latency equals STAGES when never stalled.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
package addsub_pkg;

  // Per-stage control bundle carried alongside each beat.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  // Mode encoding for the sub input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of the operand slice handled by one pipeline stage.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit adder slice with carry-in; also exposes the carry into its MSB.
module addsub_chunk #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_cmsb
);

  logic [CW:0] w_full;

  // Slice sum at CW+1 bits so the carry-out falls out of the top bit.
  always_comb begin
    w_full = (CW+1)'(i_a) + (CW+1)'(i_b) + (CW+1)'(i_cin);
  end

  assign o_sum  = w_full[CW-1:0];
  assign o_cout = w_full[CW];
  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign o_cmsb = i_a[CW-1] ^ i_b[CW-1] ^ w_full[CW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one operand chunk per stage, carry registered between stages,
// valid/ready handshake with a global stall.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW   = chunk_width(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;

  // Reject configurations that cannot be split into equal chunks.
  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Stage registers: control, operand skew (next chunk at LSB), de-skewed sum.
  stage_ctrl_t      r_ctrl [STAGES];
  logic [WIDTH-1:0] r_a    [STAGES];
  logic [WIDTH-1:0] r_b    [STAGES];
  logic [WIDTH-1:0] r_sum  [STAGES];
  logic             r_ovf;
  logic             r_zero;

  // Per-stage inputs and slice results.
  logic [WIDTH-1:0] w_src_a     [STAGES];
  logic [WIDTH-1:0] w_src_b     [STAGES];
  logic [WIDTH-1:0] w_src_sum   [STAGES];
  logic             w_src_valid [STAGES];
  logic             w_src_carry [STAGES];
  logic             w_cout      [STAGES];
  logic             w_cmsb      [STAGES];
  logic [WIDTH-1:0] w_stage_sum [STAGES];

  logic             w_stall;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  assign w_stall  = r_ctrl[LAST].valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_b_eff  = (sub == MODE_SUB) ? ~b : b;
  assign w_c0     = cin ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0] w_csum;
    logic          w_co;
    logic          w_cm;

    if (k == 0) begin : g_first
      assign w_src_a[k]     = a;
      assign w_src_b[k]     = w_b_eff;
      assign w_src_sum[k]   = '0;
      assign w_src_valid[k] = in_valid & in_ready;
      assign w_src_carry[k] = w_c0;
    end else begin : g_next
      assign w_src_a[k]     = r_a[k-1];
      assign w_src_b[k]     = r_b[k-1];
      assign w_src_sum[k]   = r_sum[k-1];
      assign w_src_valid[k] = r_ctrl[k-1].valid;
      assign w_src_carry[k] = r_ctrl[k-1].carry;
    end

    addsub_chunk #(.CW(CW)) u_chunk (
      .i_a   (w_src_a[k][CW-1:0]),
      .i_b   (w_src_b[k][CW-1:0]),
      .i_cin (w_src_carry[k]),
      .o_sum (w_csum),
      .o_cout(w_co),
      .o_cmsb(w_cm)
    );

    assign w_cout[k] = w_co;
    assign w_cmsb[k] = w_cm;
    // New chunk enters at the top while earlier chunks shift down toward bit 0.
    assign w_stage_sum[k] = (w_src_sum[k] >> CW) | (WIDTH'(w_csum) << (WIDTH - CW));
  end

  // Pipeline advance: everything holds on stall; data registers only load real beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= '0;
        r_a[k]    <= '0;
        r_b[k]    <= '0;
        r_sum[k]  <= '0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k].valid <= w_src_valid[k];
        if (w_src_valid[k]) begin
          r_ctrl[k].carry <= w_cout[k];
          r_a[k]          <= w_src_a[k] >> CW;
          r_b[k]          <= w_src_b[k] >> CW;
          r_sum[k]        <= w_stage_sum[k];
        end
      end
      if (w_src_valid[LAST]) begin
        r_ovf  <= w_cmsb[LAST] ^ w_cout[LAST];
        r_zero <= (w_stage_sum[LAST] == '0);
      end
    end
  end

  assign out_valid = r_ctrl[LAST].valid;
  assign sum       = r_sum[LAST];
  assign cout      = r_ctrl[LAST].carry;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed cases plus randomized traffic
// against an arithmetic reference model, across several STAGES settings.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  localparam int unsigned NRAND = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: WIDTH=32, STAGES=4
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cout, ovf, zero;

  // Narrow DUT: WIDTH=8, STAGES=1
  logic       v8, rdy8, ovalid8, ordy8, cin8, sub8, cout8, ovf8, zero8;
  logic [7:0] a8, b8, sum8;

  // Side DUTs: WIDTH=32, STAGES 1/2/8, never stalled
  logic             side_ordy;
  logic [2:0]       sd_ready, sd_valid, sd_cout, sd_ovf, sd_zero;
  logic [2:0][31:0] sd_sum;

  int   n_chk, n_err, n_emit, n_inrdy_lo;
  res_t exp_q[$];
  logic hist_v [NRAND];
  res_t hist_r [NRAND];

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ovalid8), .out_ready(ordy8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  for (genvar g = 0; g < 3; g++) begin : g_side
    localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    pipelined_addsub #(.WIDTH(32), .STAGES(S)) u_side (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sd_ready[g]),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(sd_valid[g]), .out_ready(side_ordy),
      .sum(sd_sum[g]), .cout(sd_cout[g]), .ovf(sd_ovf[g]), .zero(sd_zero[g])
    );
  end

  // Reference: {cout,sum} = a + b_eff + c0; signed overflow by operand/result sign rule.
  function automatic res_t ref_model(input int unsigned w, input logic [31:0] x,
                                     input logic [31:0] y, input logic ci, input logic sb);
    logic [63:0] mask, xe, ye, full, s;
    res_t r;
    mask   = (64'd1 << w) - 64'd1;
    xe     = 64'(x) & mask;
    ye     = (sb ? ~64'(y) : 64'(y)) & mask;
    full   = xe + ye + 64'(ci ^ sb);
    s      = full & mask;
    r.sum  = 32'(s);
    r.cout = full[w];
    r.ovf  = (xe[w-1] == ye[w-1]) && (s[w-1] != xe[w-1]);
    r.zero = (s == 64'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] s, input logic co,
                         input logic ov, input logic z, input res_t e);
    chk({tag, ".sum"},  s,       e.sum);
    chk({tag, ".cout"}, 32'(co), 32'(e.cout));
    chk({tag, ".ovf"},  32'(ov), 32'(e.ovf));
    chk({tag, ".zero"}, 32'(z),  32'(e.zero));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of main-DUT traffic with scoreboard tracking; returns whether the beat was taken.
  task automatic main_cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                            input logic ici, input logic isb, input logic ordy,
                            output logic acc);
    logic emit;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ici;
    sub       = isb;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (!in_ready) n_inrdy_lo++;
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
      else chk_res("beat", sum, cout, ovf, zero, exp_q[0]);
    end
    acc  = iv && in_ready;
    emit = out_valid && out_ready;
    @(posedge clk);
    if (emit && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      n_emit++;
    end
    if (acc) exp_q.push_back(ref_model(32, ia, ib, ici, isb));
    #1;
  endtask

  // Single beat on an empty main pipeline; result must appear after exactly 4 edges.
  task automatic run_one(input logic [31:0] ia, input logic [31:0] ib, input logic ici,
                         input logic isb, input res_t e, input string tag);
    in_valid  = 1'b1;
    a         = ia;
    b         = ib;
    cin       = ici;
    sub       = isb;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".early"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk_res(tag, sum, cout, ovf, zero, e);
    tick();
    chk({tag, ".gone"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic        acc, iv, ici, isb, ordy, ev;
    logic [31:0] ia, ib;
    int          idx, s, src;

    n_chk = 0; n_err = 0; n_emit = 0; n_inrdy_lo = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; ordy8 = 1'b1; side_ordy = 1'b1;

    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk_res("rst", sum, cout, ovf, zero, '{32'd0, 1'b0, 1'b0, 1'b0});
    chk("rst.out_valid8", 32'(ovalid8), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}, "wrap");
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}, "ovf_pos");
    run_one(32'd5,         32'd7,         1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}, "sub_neg");

    // Six back-to-back beats with the consumer stalling for three cycles mid-stream
    idx = 0; n_emit = 0; n_inrdy_lo = 0; exp_q.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      main_cycle(idx < 6, 32'(idx + 1), 32'(16 * (idx + 1)), 1'b0, 1'b0,
                 !(cyc >= 4 && cyc <= 6), acc);
      if (acc) idx++;
    end
    chk("stall.emitted", 32'(n_emit), 32'd6);
    chk("stall.leftover", 32'(exp_q.size()), 32'd0);
    chk("stall.in_ready_low_cycles", 32'(n_inrdy_lo), 32'd3);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'(100 + i); b = 32'd1; cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("inrst.out_valid", 32'(out_valid), 32'd0);
    chk_res("inrst", sum, cout, ovf, zero, '{32'd0, 1'b0, 1'b0, 1'b0});
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      chk("post_rst.stale", 32'(out_valid), 32'd0);
      tick();
    end
    run_one(32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, '{32'h0000_2345, 1'b0, 1'b0, 1'b0}, "after_rst");

    // 8-bit single-stage instance
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0;
    tick();
    chk("w8a.valid", 32'(ovalid8), 32'd1);
    chk_res("w8a", 32'(sum8), cout8, ovf8, zero8, '{32'h01, 1'b1, 1'b0, 1'b0});
    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1;
    tick();
    chk("w8b.valid", 32'(ovalid8), 32'd1);
    chk_res("w8b", 32'(sum8), cout8, ovf8, zero8, '{32'h7F, 1'b1, 1'b1, 1'b0});
    v8 = 1'b0;
    tick();
    chk("w8.idle", 32'(ovalid8), 32'd0);

    // Randomized traffic: main DUT with random backpressure, side DUTs free-running
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int t = 0; t < NRAND; t++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ia   = $urandom;
      ib   = $urandom;
      ici  = 1'($urandom_range(0, 1));
      isb  = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 9) < 7);
      hist_v[t] = iv;
      hist_r[t] = ref_model(32, ia, ib, ici, isb);
      main_cycle(iv, ia, ib, ici, isb, ordy, acc);
      for (int g = 0; g < 3; g++) begin
        s   = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        src = t - s + 1;
        ev  = (src >= 0) ? hist_v[src] : 1'b0;
        chk("side.valid", 32'(sd_valid[g]), 32'(ev));
        if (ev) chk_res("side", sd_sum[g], sd_cout[g], sd_ovf[g], sd_zero[g], hist_r[src]);
      end
    end
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      main_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    end
    chk("rand.drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
